// File: rtl/pgm_cfg_wr.sv
// Config-packet consumer: programs RAM banks from packets addressed to MODULE_ID,
// handles bypass opcodes, and forwards every other packet with one cycle of latency.
module pgm_cfg_wr #(
  parameter logic [7:0] MODULE_ID = 8'd70,
  parameter int         NUM_BANK  = 2,
  parameter int         DEPTH     = 128,
  parameter int         RAM_W     = 128,
  localparam int        AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [133:0]        cin_wr_data,
  input  logic                cin_wr_data_wr,
  output logic                cout_wr_ready,
  output logic [133:0]        cout_wr_data,
  output logic                cout_wr_data_wr,
  input  logic                cin_wr_ready,
  output logic [NUM_BANK-1:0] wr2ram_wr_en,
  output logic [RAM_W-1:0]    wr2ram_wdata,
  output logic [AW-1:0]       wr2ram_addr,
  output logic                pgm_bypass_flag,
  output logic                pgm_sent_start_flag,
  output logic                pgm_sent_finish_flag,
  output logic                pgm_err
);

  typedef enum logic [1:0] {S_IDLE, S_PROG, S_DROP, S_FWD} state_t;

  state_t state_q, state_nxt;

  logic [2:0]  bank_q, bank_nxt;
  // One bit wider than the header field so out-of-range addresses never wrap back into the RAM.
  logic [16:0] addr_q, addr_nxt;
  logic [15:0] cnt_q, cnt_nxt;
  logic [15:0] idx_q, idx_nxt;
  logic        pend_fin_q, pend_fin_nxt;

  logic [133:0]        fwd_data_nxt;
  logic                fwd_vld_nxt;
  logic [NUM_BANK-1:0] wr_en_nxt;
  logic [RAM_W-1:0]    wdata_nxt;
  logic [AW-1:0]       waddr_nxt;
  logic                bypass_nxt, start_nxt, fin_nxt, err_nxt;

  logic       is_head, is_tail, is_single, match;
  logic [2:0] opcode;

  assign cout_wr_ready = cin_wr_ready;

  assign is_head   = (cin_wr_data[133:132] == 2'b01);
  assign is_tail   = (cin_wr_data[133:132] == 2'b10);
  assign is_single = (cin_wr_data[133:132] == 2'b00);
  assign opcode    = cin_wr_data[126:124];
  assign match     = cin_wr_data[127] && (cin_wr_data[111:104] == MODULE_ID);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt    = state_q;
    bank_nxt     = bank_q;
    addr_nxt     = addr_q;
    cnt_nxt      = cnt_q;
    idx_nxt      = idx_q;
    pend_fin_nxt = 1'b0;
    fwd_data_nxt = cout_wr_data;
    fwd_vld_nxt  = 1'b0;
    wr_en_nxt    = '0;
    wdata_nxt    = wr2ram_wdata;
    waddr_nxt    = wr2ram_addr;
    bypass_nxt   = pgm_bypass_flag;
    start_nxt    = 1'b0;
    fin_nxt      = pend_fin_q;
    err_nxt      = pgm_err;

    if (cin_wr_data_wr) begin
      case (state_q)
        S_IDLE: begin
          if (is_head || is_single) begin
            if (match) begin
              case (opcode)
                3'b001: begin
                  bank_nxt  = cin_wr_data[102:100];
                  addr_nxt  = {1'b0, cin_wr_data[79:64]};
                  cnt_nxt   = cin_wr_data[63:48];
                  idx_nxt   = '0;
                  start_nxt = 1'b1;
                  // A single-word program has no entries: finish follows start directly.
                  pend_fin_nxt = is_single;
                end
                3'b010:  bypass_nxt = 1'b1;
                3'b011:  bypass_nxt = 1'b0;
                default: err_nxt    = 1'b1;
              endcase
              if (is_head) state_nxt = (opcode == 3'b001) ? S_PROG : S_DROP;
            end else begin
              fwd_vld_nxt  = 1'b1;
              fwd_data_nxt = cin_wr_data;
              if (is_head) state_nxt = S_FWD;
            end
          end
          // Orphan body/tail words (e.g. after a reset mid-packet) are discarded.
        end

        S_PROG: begin
          if (is_head) err_nxt = 1'b1;
          if (idx_q < cnt_q) begin
            idx_nxt  = idx_q + 16'd1;
            addr_nxt = addr_q + 17'd1;
            if ((addr_q >= 17'(DEPTH)) || ({1'b0, bank_q} >= 4'(NUM_BANK))) begin
              err_nxt = 1'b1;
            end else begin
              for (int b = 0; b < NUM_BANK; b++) wr_en_nxt[b] = (bank_q == 3'(b));
              wdata_nxt = cin_wr_data[RAM_W-1:0];
              waddr_nxt = addr_q[AW-1:0];
            end
          end
          if (is_tail) begin
            state_nxt = S_IDLE;
            fin_nxt   = 1'b1;
            if (idx_nxt < cnt_q) err_nxt = 1'b1;
          end
        end

        S_DROP: begin
          if (is_head) err_nxt = 1'b1;
          if (is_tail) state_nxt = S_IDLE;
        end

        S_FWD: begin
          if (is_head) err_nxt = 1'b1;
          fwd_vld_nxt  = 1'b1;
          fwd_data_nxt = cin_wr_data;
          if (is_tail) state_nxt = S_IDLE;
        end

        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= S_IDLE;
      bank_q               <= '0;
      addr_q               <= '0;
      cnt_q                <= '0;
      idx_q                <= '0;
      pend_fin_q           <= 1'b0;
      cout_wr_data         <= '0;
      cout_wr_data_wr      <= 1'b0;
      wr2ram_wr_en         <= '0;
      wr2ram_wdata         <= '0;
      wr2ram_addr          <= '0;
      pgm_bypass_flag      <= 1'b0;
      pgm_sent_start_flag  <= 1'b0;
      pgm_sent_finish_flag <= 1'b0;
      pgm_err              <= 1'b0;
    end else begin
      state_q              <= state_nxt;
      bank_q               <= bank_nxt;
      addr_q               <= addr_nxt;
      cnt_q                <= cnt_nxt;
      idx_q                <= idx_nxt;
      pend_fin_q           <= pend_fin_nxt;
      cout_wr_data         <= fwd_data_nxt;
      cout_wr_data_wr      <= fwd_vld_nxt;
      wr2ram_wr_en         <= wr_en_nxt;
      wr2ram_wdata         <= wdata_nxt;
      wr2ram_addr          <= waddr_nxt;
      pgm_bypass_flag      <= bypass_nxt;
      pgm_sent_start_flag  <= start_nxt;
      pgm_sent_finish_flag <= fin_nxt;
      pgm_err              <= err_nxt;
    end
  end

endmodule
